core_insn_loader: RTL and testbench

- Per-core receiving end of the Task Scheduler instruction-delivery interface; one instance per core.
- Consumes the core's Start bit, the shared load counter and the instruction bus, and reassembles the INSN_LOAD_TIME parts into a full instruction frame.
- Hands the frame to the core pipeline through a valid/ack handshake and drives the core's Ready bit back to the scheduler.
- Also captures the core's Init_R0 slice.

---
 rtl/core_insn_loader.sv | 135 +++++++++++++
 tb/tb_core_insn_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_insn_loader.sv
// Per-core instruction loader: reassembles multi-part instruction frames from the
// scheduler bus, hands them to the core pipeline and captures the R0 init value.
module core_insn_loader #(
    parameter int unsigned INSN_BUS_W     = 64,
    parameter int unsigned INSN_LOAD_TIME = 4,
    parameter int unsigned CNT_W          = $clog2(INSN_LOAD_TIME),
    parameter int unsigned REG_W          = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [CNT_W-1:0]                     insn_load_counter,
    input  logic [INSN_BUS_W-1:0]                insn_data,
    input  logic                                 init_r0_vect_bit,
    input  logic [REG_W-1:0]                     init_r0,
    output logic                                 ready,
    output logic [INSN_BUS_W*INSN_LOAD_TIME-1:0] frame_data,
    output logic                                 frame_valid,
    input  logic                                 frame_ack,
    input  logic                                 core_done,
    output logic [REG_W-1:0]                     r0_value,
    output logic                                 r0_we,
    output logic                                 seq_error
);

    localparam int unsigned      FRAME_W   = INSN_BUS_W * INSN_LOAD_TIME;
    localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(INSN_LOAD_TIME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;
    logic               seq_error_q, seq_error_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               vect_prev_q;
    logic [REG_W-1:0]   r0_value_q;
    logic               r0_we_q;

    // Next-state, part write, sequence tracking and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        exp_cnt_d   = exp_cnt_q;
        seq_error_d = seq_error_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned k = 0; k < INSN_LOAD_TIME; k++) begin
                        if (insn_load_counter == CNT_W'(k)) begin
                            frame_d[k*INSN_BUS_W +: INSN_BUS_W] = insn_data;
                        end
                    end
                    if (insn_load_counter != exp_cnt_q) begin
                        seq_error_d = 1'b1;
                    end
                    // Resynchronise to the index actually seen, wrapping after the last part
                    exp_cnt_d = (insn_load_counter == LAST_PART) ? '0
                                                                 : insn_load_counter + CNT_W'(1);
                    if (insn_load_counter == LAST_PART) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (start) begin
                    seq_error_d = 1'b1;
                end
                if (frame_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (start) begin
                    seq_error_d = 1'b1;
                end
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == ISSUE);
    end

    // Loader state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            exp_cnt_q   <= '0;
            seq_error_q <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            exp_cnt_q   <= exp_cnt_d;
            seq_error_q <= seq_error_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    // R0 capture on the rising edge of the init vector bit, independent of the loader
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vect_prev_q <= 1'b0;
            r0_value_q  <= '0;
            r0_we_q     <= 1'b0;
        end else begin
            vect_prev_q <= init_r0_vect_bit;
            r0_we_q     <= init_r0_vect_bit & ~vect_prev_q;
            if (init_r0_vect_bit && !vect_prev_q) begin
                r0_value_q <= init_r0;
            end
        end
    end

    assign ready       = ready_q;
    assign frame_valid = valid_q;
    assign frame_data  = frame_q;
    assign seq_error   = seq_error_q;
    assign r0_value    = r0_value_q;
    assign r0_we       = r0_we_q;

endmodule

// File: tb/tb_core_insn_loader.sv
// Self-checking bench for core_insn_loader: frame and R0 scoreboards plus direct checks.
module tb_core_insn_loader;

    localparam int unsigned BW = 64;
    localparam int unsigned LT = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned RW = 8;
    localparam int unsigned FW = BW * LT;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] insn_load_counter;
    logic [BW-1:0] insn_data;
    logic          init_r0_vect_bit;
    logic [RW-1:0] init_r0;
    logic          ready;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ack;
    logic          core_done;
    logic [RW-1:0] r0_value;
    logic          r0_we;
    logic          seq_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [FW-1:0] frame_sb[$];
    logic [RW-1:0] r0_sb[$];

    core_insn_loader #(
        .INSN_BUS_W    (BW),
        .INSN_LOAD_TIME(LT),
        .CNT_W         (CW),
        .REG_W         (RW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .insn_load_counter(insn_load_counter),
        .insn_data        (insn_data),
        .init_r0_vect_bit (init_r0_vect_bit),
        .init_r0          (init_r0),
        .ready            (ready),
        .frame_data       (frame_data),
        .frame_valid      (frame_valid),
        .frame_ack        (frame_ack),
        .core_done        (core_done),
        .r0_value         (r0_value),
        .r0_we            (r0_we),
        .seq_error        (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then stable and new inputs apply to the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Drive nparts parts in order; optional stall after part gap_after; optional R0 edge on last part
    task automatic load_frame(input logic [FW-1:0] f, input int nparts, input int gap_after,
                              input int gap_len, input bit r0_on_last, input logic [RW-1:0] r0v);
        if (nparts == int'(LT)) frame_sb.push_back(f);
        for (int k = 0; k < nparts; k++) begin
            start             = 1'b1;
            insn_load_counter = CW'(k);
            insn_data         = f[k*BW +: BW];
            if (k == int'(LT) - 1 && r0_on_last) begin
                init_r0          = r0v;
                init_r0_vect_bit = 1'b1;
                r0_sb.push_back(r0v);
            end
            tick();
            if (k == gap_after) begin
                start             = 1'b0;
                insn_load_counter = CW'(k + 1);
                insn_data         = {$urandom, $urandom};
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    check("gap_ready", {255'd0, ready}, 1);
                    check("gap_valid", {255'd0, frame_valid}, 0);
                end
            end
        end
        start = 1'b0;
    endtask

    // Bounded wait for frame_valid, then compare against the scoreboard head
    task automatic wait_frame();
        int t = 0;
        while (!frame_valid && t < 20) begin
            tick();
            t++;
        end
        if (!frame_valid) check("frame_timeout", 0, 1);
        else if (frame_sb.size() == 0) check("frame_unexpected", 1, 0);
        else check("frame_data", frame_data, frame_sb.pop_front());
    endtask

    // R0 monitor: every r0_we pulse must match a pending expected capture
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r0_we === 1'b1) begin
                if (r0_sb.size() == 0) check("r0_we_extra", 1, 0);
                else check("r0_value", {248'd0, r0_value}, {248'd0, r0_sb.pop_front()});
            end
        end
    end

    logic [FW-1:0] f1, f2, f3, f_hold;

    initial begin
        f1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        f2 = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 64'h0F1E_2D3C_4B5A_6978, 64'hA5A5_5A5A_C3C3_3C3C};
        f3 = {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003, 64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001};
        reset = 1'b0; start = 1'b0; insn_load_counter = '0; insn_data = '0;
        init_r0_vect_bit = 1'b0; init_r0 = '0; frame_ack = 1'b0; core_done = 1'b0;
        repeat (2) tick();
        check("rst_ready", {255'd0, ready}, 1);
        check("rst_valid", {255'd0, frame_valid}, 0);
        check("rst_data", frame_data, 0);
        check("rst_seq_error", {255'd0, seq_error}, 0);
        check("rst_r0", {248'd0, r0_value}, 0);
        reset = 1'b1;
        tick();

        // Basic 4-part load, one-cycle latency, then ack and done
        load_frame(f1, 4, -1, 0, 1'b0, 8'h00);
        check("lat_valid", {255'd0, frame_valid}, 1);
        check("lat_ready", {255'd0, ready}, 0);
        wait_frame();
        check("f1_seq_error", {255'd0, seq_error}, 0);
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        check("exec_valid", {255'd0, frame_valid}, 0);
        check("exec_ready", {255'd0, ready}, 0);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("done_ready", {255'd0, ready}, 1);

        // Stalled scheduler after part 1, then zero-wait ack
        load_frame(f1, 4, 1, 5, 1'b0, 8'h00);
        wait_frame();
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        check("zw_exec_valid", {255'd0, frame_valid}, 0);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("gap_seq_error", {255'd0, seq_error}, 0);

        // Ack held off 3 cycles; frame must hold
        load_frame(f2, 4, -1, 0, 1'b0, 8'h00);
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", {255'd0, frame_valid}, 1);
            check("hold_data", frame_data, f2);
        end
        // Ack and done together in ISSUE: only the ack acts
        frame_ack = 1'b1; core_done = 1'b1; tick(); frame_ack = 1'b0; core_done = 1'b0;
        check("ackdone_valid", {255'd0, frame_valid}, 0);
        check("ackdone_ready", {255'd0, ready}, 0);
        // Start while in EXEC flags an error and leaves the frame alone
        start = 1'b1; insn_load_counter = 2'd0; insn_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); start = 1'b0;
        check("exec_start_err", {255'd0, seq_error}, 1);
        check("exec_start_data", frame_data, f2);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("done2_ready", {255'd0, ready}, 1);

        // Out-of-order counter 0,2 sets a sticky error
        do_reset();
        check("rst2_seq_error", {255'd0, seq_error}, 0);
        start = 1'b1; insn_load_counter = 2'd0; insn_data = 64'h1; tick();
        insn_load_counter = 2'd2; insn_data = 64'h2; tick();
        start = 1'b0;
        check("skip_seq_error", {255'd0, seq_error}, 1);
        repeat (3) tick();
        check("sticky_seq_error", {255'd0, seq_error}, 1);
        check("skip_idle_ready", {255'd0, ready}, 1);

        // R0 capture: one pulse for a held-high vector bit
        init_r0 = 8'h5A; init_r0_vect_bit = 1'b1; r0_sb.push_back(8'h5A);
        repeat (4) tick();
        init_r0 = 8'h77;
        tick();
        check("r0_hold_value", {248'd0, r0_value}, {248'd0, 8'h5A});
        init_r0_vect_bit = 1'b0;
        tick();

        // Reset in the middle of a load discards the partial frame
        f_hold = f3;
        load_frame(f_hold, 3, -1, 0, 1'b0, 8'h00);
        do_reset();
        check("mid_rst_ready", {255'd0, ready}, 1);
        check("mid_rst_valid", {255'd0, frame_valid}, 0);
        check("mid_rst_data", frame_data, 0);
        check("mid_rst_seq_error", {255'd0, seq_error}, 0);

        // Fresh load with an R0 edge on the final part
        load_frame(f3, 4, -1, 0, 1'b1, 8'h3C);
        check("f3_valid", {255'd0, frame_valid}, 1);
        wait_frame();
        init_r0_vect_bit = 1'b0;
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("f3_ready", {255'd0, ready}, 1);
        check("f3_seq_error", {255'd0, seq_error}, 0);
        check("f3_r0", {248'd0, r0_value}, {248'd0, 8'h3C});

        repeat (2) tick();
        check("r0_pending", FW'(r0_sb.size()), 0);
        check("frame_pending", FW'(frame_sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
